robot_controller: RTL
=====================

# robot_controller

Decision core of the pipe-cleaning robot. It is the consumer end of the world/robot interface: the world model presents obstacle and dirt sensor readings, and this block answers each reading with exactly one movement command. Navigation uses a left-hand wall-following state machine. The block also counts advances and detects a robot boxed in by walls.

## Interface
Parameters:
- `MAX_TURNS`, default 4: number of consecutive turns without an advance that declares the robot stuck. Legal range 2..15.
- `STEP_W`, default 16: width of the advance counter.

Ports:
- `clock`, in, 1: rising-edge clock.
- `reset`, in, 1: asynchronous, active-low reset.
- `sensors_valid`, in, 1: one-cycle strobe; sensor inputs are valid in this cycle.
- `head`, in, 1: obstacle in the cell ahead.
- `left`, in, 1: obstacle in the cell to the left.
- `under`, in, 1: dirt in the current cell.
- `cmd`, out, 2: command code. 00 = advance, 01 = turn right, 10 = turn left, 11 = remove dirt.
- `cmd_valid`, out, 1: one-cycle strobe; `cmd` is valid.
- `stuck`, out, 1: sticky flag; the robot is enclosed.
- `step_count`, out, STEP_W: number of advances issued, saturating.

## Operation
States: SEARCH, FOLLOW, STUCK_ST.

Decisions are made only when `sensors_valid`=1 and the state is not STUCK_ST. Priority is top-down in each list; the first matching rule wins.

SEARCH (no wall acquired yet):
- `under`=1: remove. State unchanged.
- `head`=1: turn right. Go to FOLLOW.
- Otherwise: advance.

FOLLOW:
- `under`=1: remove.
- `left`=0 and `just_left`=0: turn left. Set `just_left`.
- `head`=0: advance. Clear `just_left`.
- Otherwise: turn right. Clear `just_left`.

Internal state:
- `just_left` prevents endless left spins in open space. It is cleared by advance and by turn right. Remove leaves it unchanged.
- `turn_cnt` (4 bits):
  - Turn right or turn left: increment.
  - Advance: clear.
  - Remove: unchanged.
- When a turn makes `turn_cnt` equal `MAX_TURNS`:
  - That turn command is still issued.
  - `stuck` asserts in the same cycle as its `cmd_valid`.
  - The state becomes STUCK_ST.
- STUCK_ST: every `sensors_valid` is ignored. No `cmd_valid` is produced. Only `reset` exits this state.

`step_count`:
- Increments on each issued advance.
- Saturates at all-ones and does not wrap.
- Remove and turns do not change it.

## Timing
- Reset (async assert, `reset`=0): state=SEARCH, `cmd`=00, `cmd_valid`=0, `stuck`=0, `step_count`=0, `turn_cnt`=0, `just_left`=0. All of these take effect immediately, with no clock edge needed.
- Latency: sensors are sampled on the edge where `sensors_valid`=1. `cmd` and `cmd_valid` are registered and visible the following cycle. `cmd_valid` is high for exactly one cycle.
- Throughput: `sensors_valid` may be high every cycle. Each strobe produces one command one cycle later, so back-to-back commands are legal.
- `cmd` holds its last value while `cmd_valid`=0. Sinks must qualify `cmd` with `cmd_valid`.
- Sensor inputs are don't-care when `sensors_valid`=0.
- Reset asserted mid-decision, between a strobe and its `cmd_valid`: the pending command is dropped and `cmd_valid` stays 0.
- `stuck`, `step_count` and the state update on the same edge that raises `cmd_valid`.

## Test plan
- **Reset values:** hold `reset`=0 for 3 cycles, then release → `cmd_valid`=0, `stuck`=0, `step_count`=0 and state=SEARCH, both during and after reset.
- **Open-space search:** 5 strobes with `head`=`left`=`under`=0 → 5 advances, each arriving one cycle after its strobe; `step_count`=5.
- **Wall acquisition and left rule:**
  - Strobe `head`=1 → turn right; state becomes FOLLOW.
  - Strobe `left`=0, `head`=0 → turn left.
  - Strobe `left`=0, `head`=0 again → advance, because `just_left` was set.
- **Dirt priority:** in FOLLOW, strobe `under`=1, `head`=1, `left`=0 → remove. `turn_cnt`, `just_left` and `step_count` are unchanged.
- **Enclosure:** in FOLLOW, 4 strobes with `head`=`left`=1 → 4 turn-right commands; `stuck`=1 together with the 4th `cmd_valid`. A 5th strobe produces no `cmd_valid`.
- **Saturation and mid-flight reset:**
  - With `STEP_W`=3, 9 advances → `step_count`=7.
  - Assert `reset` in the cycle after a strobe → no `cmd_valid` follows.

Source files
------------

// File: rtl/robot_controller_if.sv
// World/robot link: sensor strobe from the world model, command strobe and
// status back from the controller.
interface robot_controller_if #(
  parameter int STEP_W = 16
);
  logic              sensors_valid;
  logic              head;
  logic              left;
  logic              under;
  logic [1:0]        cmd;
  logic              cmd_valid;
  logic              stuck;
  logic [STEP_W-1:0] step_count;

  // World model side: produces sensor readings, consumes commands.
  modport master (
    output sensors_valid, head, left, under,
    input  cmd, cmd_valid, stuck, step_count
  );

  // Controller side: consumes sensor readings, produces commands.
  modport slave (
    input  sensors_valid, head, left, under,
    output cmd, cmd_valid, stuck, step_count
  );
endinterface

// File: rtl/robot_controller.sv
// Decision core of the pipe-cleaning robot: left-hand wall follower that
// answers every sensor strobe with one registered command, counts advances
// and latches a sticky stuck flag when it keeps turning without progress.
module robot_controller #(
  parameter int MAX_TURNS = 4,
  parameter int STEP_W    = 16
) (
  input  logic           clock,
  input  logic           reset,
  robot_controller_if.slave bus
);

  typedef enum logic [1:0] {
    SEARCH   = 2'd0,
    FOLLOW   = 2'd1,
    STUCK_ST = 2'd2
  } state_e;

  localparam logic [1:0]        CMD_ADV   = 2'b00;
  localparam logic [1:0]        CMD_RIGHT = 2'b01;
  localparam logic [1:0]        CMD_LEFT  = 2'b10;
  localparam logic [1:0]        CMD_REM   = 2'b11;
  localparam logic [STEP_W-1:0] STEP_MAX  = {STEP_W{1'b1}};
  localparam logic [3:0]        TURN_LIM  = 4'(MAX_TURNS);

  state_e            state_q, state_d;
  logic [1:0]        cmd_q, cmd_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic              stuck_q, stuck_d;
  logic [STEP_W-1:0] step_count_q, step_count_d;
  logic [3:0]        turn_cnt_q, turn_cnt_d;
  logic              just_left_q, just_left_d;

  logic              issue_s;
  logic [1:0]        sel_cmd_s;
  logic [3:0]        turn_inc_s;

  assign turn_inc_s = turn_cnt_q + 4'd1;

  // Pick the command for this strobe; dirt removal always wins.
  always_comb begin
    issue_s   = 1'b0;
    sel_cmd_s = CMD_ADV;
    if (bus.sensors_valid && (state_q != STUCK_ST)) begin
      issue_s = 1'b1;
      if (bus.under) begin
        sel_cmd_s = CMD_REM;
      end else begin
        case (state_q)
          SEARCH: begin
            if (bus.head) sel_cmd_s = CMD_RIGHT;
            else          sel_cmd_s = CMD_ADV;
          end
          FOLLOW: begin
            // just_left stops a second left turn before we have moved.
            if (!bus.left && !just_left_q) sel_cmd_s = CMD_LEFT;
            else if (!bus.head)            sel_cmd_s = CMD_ADV;
            else                           sel_cmd_s = CMD_RIGHT;
          end
          default: sel_cmd_s = CMD_ADV;
        endcase
      end
    end else begin
      issue_s   = 1'b0;
      sel_cmd_s = CMD_ADV;
    end
  end

  // Apply the chosen command to state, counters and outputs.
  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    cmd_valid_d  = 1'b0;
    stuck_d      = stuck_q;
    step_count_d = step_count_q;
    turn_cnt_d   = turn_cnt_q;
    just_left_d  = just_left_q;
    if (issue_s) begin
      cmd_valid_d = 1'b1;
      cmd_d       = sel_cmd_s;
      case (sel_cmd_s)
        CMD_ADV: begin
          turn_cnt_d  = 4'd0;
          just_left_d = 1'b0;
          if (step_count_q != STEP_MAX) step_count_d = step_count_q + STEP_W'(1);
          else                          step_count_d = step_count_q;
        end
        CMD_RIGHT, CMD_LEFT: begin
          turn_cnt_d  = turn_inc_s;
          just_left_d = (sel_cmd_s == CMD_LEFT);
          // The first right turn in SEARCH means a wall has been found.
          if (turn_inc_s == TURN_LIM) begin
            stuck_d = 1'b1;
            state_d = STUCK_ST;
          end else begin
            state_d = FOLLOW;
          end
        end
        CMD_REM: begin
          turn_cnt_d = turn_cnt_q;
        end
        default: begin
          cmd_valid_d = 1'b0;
        end
      endcase
    end else begin
      cmd_valid_d = 1'b0;
    end
  end

  // State and output registers; reset clears any command in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= SEARCH;
      cmd_q        <= CMD_ADV;
      cmd_valid_q  <= 1'b0;
      stuck_q      <= 1'b0;
      step_count_q <= {STEP_W{1'b0}};
      turn_cnt_q   <= 4'd0;
      just_left_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      cmd_valid_q  <= cmd_valid_d;
      stuck_q      <= stuck_d;
      step_count_q <= step_count_d;
      turn_cnt_q   <= turn_cnt_d;
      just_left_q  <= just_left_d;
    end
  end

  assign bus.cmd        = cmd_q;
  assign bus.cmd_valid  = cmd_valid_q;
  assign bus.stuck      = stuck_q;
  assign bus.step_count = step_count_q;

endmodule
